// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution pipeline: RV32I branch funct3
// codes, the registered result flags, and the illegal-encoding helper.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef struct packed {
    logic taken;
    logic mispredict;
    logic illegal;
    logic breq;
    logic brlt;
  } br_res_t;

  // 010 and 011 are the only unused branch encodings.
  function automatic logic is_illegal(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/branch_cmp_core.sv
// Combinational operand compare: equality plus signed/unsigned less-than.
module branch_cmp_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            is_unsigned,
  output logic            eq,
  output logic            lt
);

  assign eq = (a == b);
  assign lt = is_unsigned ? (a < b) : ($signed(a) < $signed(b));

endmodule

// File: rtl/branch_resolve.sv
// Two-stage branch resolver with valid/ready flow control and flush.
// Define BRANCH_STATS_EN to add saturating branch/taken/mispredict counters.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            BrEQ,
  output logic            BrLT,
  output logic            taken,
  output logic            mispredict,
  output logic            illegal,
  output logic [XLEN-1:0] target
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_mispred
`endif
);

  logic            s1_valid, s2_valid;
  logic [2:0]      s1_f3;
  logic [XLEN-1:0] s1_pc, s1_imm;
  logic            s1_pred, s1_eq, s1_lt;
  logic            cmp_eq, cmp_lt;
  logic            s1_adv, s2_adv;
  br_res_t         res, res_nxt;
  logic [XLEN-1:0] tgt_nxt;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  branch_cmp_core #(.XLEN(XLEN)) u_cmp (
    .a          (data1),
    .b          (data2),
    .is_unsigned(funct3[1]),
    .eq         (cmp_eq),
    .lt         (cmp_lt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_f3    <= '0;
      s1_pc    <= '0;
      s1_imm   <= '0;
      s1_pred  <= 1'b0;
      s1_eq    <= 1'b0;
      s1_lt    <= 1'b0;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (s1_adv) s1_valid <= in_valid;
      if (s1_adv && in_valid && !flush) begin
        s1_f3   <= funct3;
        s1_pc   <= pc;
        s1_imm  <= imm;
        s1_pred <= pred_taken;
        s1_eq   <= cmp_eq;
        // BrLT only carries meaning for the LT/GE family (funct3[2] set).
        s1_lt   <= cmp_lt & funct3[2];
      end
    end
  end

  always_comb begin
    res_nxt = '0;
    case (s1_f3)
      BEQ:       res_nxt.taken = s1_eq;
      BNE:       res_nxt.taken = !s1_eq;
      BLT, BLTU: res_nxt.taken = s1_lt;
      BGE, BGEU: res_nxt.taken = !s1_lt;
      default:   res_nxt.taken = 1'b0;
    endcase
    res_nxt.illegal    = is_illegal(s1_f3);
    res_nxt.mispredict = !res_nxt.illegal && (res_nxt.taken ^ s1_pred);
    res_nxt.breq       = s1_eq;
    res_nxt.brlt       = s1_lt;
    tgt_nxt            = s1_pc + (res_nxt.taken ? s1_imm : XLEN'(4));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      res      <= '0;
      target   <= '0;
    end else begin
      if (flush)       s2_valid <= 1'b0;
      else if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid && !flush) begin
        res    <= res_nxt;
        target <= tgt_nxt;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign taken      = res.taken;
  assign mispredict = res.mispredict;
  assign illegal    = res.illegal;
  assign BrEQ       = res.breq;
  assign BrLT       = res.brlt;

`ifdef BRANCH_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches <= '0;
      stat_taken    <= '0;
      stat_mispred  <= '0;
    end else if (out_valid && out_ready && !res.illegal) begin
      stat_branches <= sat_inc(stat_branches);
      if (res.taken)      stat_taken   <= sat_inc(stat_taken);
      if (res.mispredict) stat_mispred <= sat_inc(stat_mispred);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed corner cases plus random traffic checked
// against an in-order scoreboard of results computed from the branch rules.
module tb_branch_resolve;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, pred_taken, flush, out_valid, out_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] data1, data2, pc, imm, target;
  logic            BrEQ, BrLT, taken, mispredict, illegal;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] stat_branches, stat_taken, stat_mispred;
`endif

  branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .data1(data1), .data2(data2), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .BrEQ(BrEQ), .BrLT(BrLT), .taken(taken),
    .mispredict(mispredict), .illegal(illegal), .target(target)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken, mp, ill, eq, lt;
    logic [31:0] tgt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   acc;
  int   m_br = 0, m_tk = 0, m_mp = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, b, p, im,
                                 input logic pr);
    exp_t e;
    logic lts, ltu;
    lts   = $signed(a) < $signed(b);
    ltu   = a < b;
    e.eq  = (a == b);
    e.ill = (f3 == 3'd2) || (f3 == 3'd3);
    case (f3)
      3'd0:    e.taken = e.eq;
      3'd1:    e.taken = !e.eq;
      3'd4:    e.taken = lts;
      3'd5:    e.taken = !lts;
      3'd6:    e.taken = ltu;
      3'd7:    e.taken = !ltu;
      default: e.taken = 1'b0;
    endcase
    e.lt  = (f3 == 3'd4 || f3 == 3'd5) ? lts : (f3 == 3'd6 || f3 == 3'd7) ? ltu : 1'b0;
    e.tgt = e.taken ? p + im : p + 32'd4;
    e.mp  = e.ill ? 1'b0 : (e.taken ^ pr);
    return e;
  endfunction

  function automatic int sat(input int v);
    return (v == (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a, b, p, im,
                       input logic pr);
    in_valid = v; funct3 = f; data1 = a; data2 = b; pc = p; imm = im; pred_taken = pr;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // One clock: check visible state against the scoreboard, apply the
  // handshakes to the model, then advance to the next falling edge.
  task automatic cycle();
    exp_t h, n;
    #1;
    chk("in_ready", in_ready, (q.size() < 2) || out_ready);
`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_branches, m_br);
    chk("stat_taken", stat_taken, m_tk);
    chk("stat_mispred", stat_mispred, m_mp);
`endif
    if (out_valid) begin
      chk("out_has_entry", q.size() > 0, 1);
      if (q.size() > 0) begin
        h = q[0];
        chk("taken", taken, h.taken);
        chk("mispredict", mispredict, h.mp);
        chk("illegal", illegal, h.ill);
        chk("BrEQ", BrEQ, h.eq);
        chk("BrLT", BrLT, h.lt);
        chk("target", target, h.tgt);
      end
    end
    acc = in_valid && in_ready;
    if (out_valid && out_ready && q.size() > 0) begin
      h = q.pop_front();
      if (!h.ill) begin
        m_br = sat(m_br);
        if (h.taken) m_tk = sat(m_tk);
        if (h.mp)    m_mp = sat(m_mp);
      end
    end
    if (flush) q.delete();
    else if (acc) begin
      n = model(funct3, data1, data2, pc, imm, pred_taken);
      q.push_back(n);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [2:0]  rf3[4];
  logic [31:0] ra[4], rb[4];
  int          idx;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idle();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_taken", taken, 0);
    chk("rst_target", target, 0);
    chk("rst_flags", {BrEQ, BrLT, mispredict, illegal}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    // signed BLT: -1 < 1
    drive(1'b1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0);
    cycle(); chk("blt_accept", acc, 1);
    idle();
    chk("blt_lat1", out_valid, 0);
    cycle();
    chk("blt_valid", out_valid, 1);
    chk("blt_taken", taken, 1);
    chk("blt_brlt", BrLT, 1);
    chk("blt_target", target, 32'h120);

    // unsigned BLTU with the same operands, predicted taken
    drive(1'b1, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b1);
    cycle(); idle(); cycle();
    chk("bltu_valid", out_valid, 1);
    chk("bltu_taken", taken, 0);
    chk("bltu_brlt", BrLT, 0);
    chk("bltu_target", target, 32'h104);
    chk("bltu_mispred", mispredict, 1);

    drive(1'b1, 3'd2, 32'd5, 32'd5, 32'h200, 32'h40, 1'b1);
    cycle(); idle(); cycle();
    chk("ill_flag", illegal, 1);
    chk("ill_taken", taken, 0);
    chk("ill_mispred", mispredict, 0);
    chk("ill_target", target, 32'h204);

    drive(1'b1, 3'd0, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'd8, 1'b0);
    cycle(); idle(); cycle();
    chk("wrap_taken", taken, 0);
    chk("wrap_target", target, 32'h0);
    cycle();

    // backpressure: 4 back-to-back requests, output stalled 3 cycles
    for (int i = 0; i < 4; i++) begin
      rf3[i] = 3'(i + 4); ra[i] = 32'(i * 7); rb[i] = 32'(20 - i * 9);
    end
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, rf3[idx], ra[idx], rb[idx], 32'h1000 + 32'(idx * 16), 32'h80, 1'b0);
      cycle();
      if (acc) idx++;
    end
    chk("bp_accepts", idx, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
      if (idx < 4) drive(1'b1, rf3[idx], ra[idx], rb[idx], 32'h1000 + 32'(idx * 16), 32'h80, 1'b0);
      else idle();
      cycle();
      if (acc && idx < 4) idx++;
    end
    chk("bp_all_accepted", idx, 4);
    chk("bp_drained", q.size(), 0);
    idle();

    // flush with both stages full and a new request offered
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'd3, 32'd3, 32'h300, 32'h10, 1'b0); cycle();
    drive(1'b1, 3'd1, 32'd3, 32'd4, 32'h304, 32'h10, 1'b0); cycle();
    chk("fl_full", out_valid, 1);
    drive(1'b1, 3'd5, 32'd9, 32'd4, 32'h308, 32'h10, 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0; idle();
    chk("fl_out_valid", out_valid, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("fl_no_result", out_valid, 0);
    end

    // random traffic
    for (int c = 0; c < 400; c++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h8000_0000;
        default: b = $urandom;
      endcase
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b,
            $urandom, $urandom, 1'($urandom_range(0, 1)));
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 39) == 0;
      cycle();
    end
    flush = 1'b0;

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 3'd4, 32'd1, 32'd2, 32'h400, 32'h8, 1'b0); cycle();
    drive(1'b1, 3'd7, 32'd1, 32'd2, 32'h404, 32'h8, 1'b0); cycle();
    idle();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_target", target, 0);
    chk("arst_taken", taken, 0);
`ifdef BRANCH_STATS_EN
    chk("arst_stats", {stat_branches, stat_taken, stat_mispred}, 0);
`endif
    q.delete(); m_br = 0; m_tk = 0; m_mp = 0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 3'd5, 32'd2, 32'd1, 32'h500, 32'h40, 1'b0);
    cycle();
    chk("post_rst_accept", acc, 1);
    idle();

    for (int c = 0; c < 20 && q.size() > 0; c++) cycle();
    chk("final_drain", q.size(), 0);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
